result_tx_seq: RTL
==================

# result_tx_seq

Serializes one completed 2x2 matrix-multiply result into a framed byte stream for the UART transmitter. Sits downstream of the hyperpacket parser and `mat_mul`, and upstream of the `uart` transmit side. It snapshots the job ID and the four result items, then emits a 7-byte frame. Each byte is released only after the UART has finished the previous one, so no byte is ever dropped by back-to-back requests.

## Interface

Parameters:
- `ACK_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a request before treating the byte as accepted.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to send a result frame.
- `job_id`  in  8  job ID for the frame; sampled on accepted `start`.
- `c11`, `c12`, `c21`, `c22`  in  8 each  result items; sampled on accepted `start`.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_byte`  out  8  byte presented to the UART; valid while `send_request`=1.
- `send_request`  out  1  single-cycle pulse that hands `tx_byte` to the UART.
- `ready`  out  1  high in IDLE; `start` is accepted only when high.
- `done`  out  1  single-cycle pulse after the last byte completes.
- `overrun`  out  1  sticky; set when `start` arrives while `ready`=0.

## Operation

- Frame order:
  - `8'hFE` (result opcode)
  - `job_id`
  - `c11`, `c12`, `c21`, `c22`
  - checksum = XOR of `job_id`, `c11`, `c12`, `c21`, `c22`. The opcode is excluded.
- All values are 8 bits. No truncation or saturation is applied; items pass through unchanged.
- States:
  - IDLE: `ready`=1. `start` latches all inputs into a 7-byte frame buffer, clears the byte index, and moves to SEND.
  - SEND: drives `tx_byte` = buffer[index] and pulses `send_request` for one cycle. Moves to WAIT_ACK and loads the timeout counter with `ACK_TIMEOUT`.
  - WAIT_ACK: `tx_busy`=1 moves to WAIT_DONE. If the counter expires with no `tx_busy`, the byte counts as accepted and the state moves to WAIT_DONE.
  - WAIT_DONE: stays while `tx_busy`=1. When `tx_busy`=0:
    - index < 6: increment the index and go to SEND.
    - index = 6: pulse `done` and go to IDLE.
- `start` while not IDLE: ignored, frame unaffected, `overrun` set. `overrun` is cleared only by `rst`.
- Input changes after acceptance have no effect on the frame in flight.
- `tx_busy` already high on entry to SEND: the request still issues, and WAIT_ACK passes immediately on busy.
- Reset mid-frame: the frame is abandoned and no further bytes are sent. The next frame starts from the opcode.

## Timing

- Reset values: `tx_byte`=0, `send_request`=0, `ready`=1, `done`=0, `overrun`=0. State is IDLE, index is 0, buffer is 0.
- `start` accepted in cycle N → `ready`=0 in N+1 → first `send_request` in N+1.
- Per byte: `send_request` pulse, then `tx_busy` rise, then `tx_busy` fall. The next `send_request` comes one cycle after the falling edge is seen.
- `done` asserts one cycle after the final `tx_busy` fall. `ready`=1 in the same cycle as `done`.
- A new `start` in the `done` cycle is accepted.
- `send_request` never asserts twice without an intervening busy-fall or a timeout.
- Minimum frame time with zero-length busy (timeout path): 7 × (1 + `ACK_TIMEOUT` + 1) cycles.

## Structure

- Shared package `mat_maven_pkg`:
  - `RESULT_OPCODE` = `8'hFE`
  - `FRAME_LEN` = 7
  - state enum `result_tx_state_t`
  - the existing mat-mul opcode `8'hFF`, so the parser and this block share constants.
- One natural sub-module, `tx_byte_handshake`. It owns the request / busy-rise / timeout / busy-fall sequencing for a single byte and returns a `byte_done` pulse. `result_tx_seq` keeps the frame buffer, index and checksum.

## Test plan

- Basic frame: `job_id`=`2A`, c=`01`,`02`,`03`,`04`; UART model holds busy 10 cycles, rising 1 cycle after each request. Required bytes in order: `FE 2A 01 02 03 04 2E`, then one `done` pulse and `ready`=1.
- Snapshot: same `start`, then change all item inputs to `FF` in the next cycle. The frame is still `FE 2A 01 02 03 04 2E`.
- Overrun: pulse `start` again during byte 3. Required: exactly one frame is sent and `overrun`=1 until `rst`.
- Timeout: UART model never asserts busy. Required: 7 requests, each spaced `ACK_TIMEOUT`+2 cycles apart, then `done`.
- Reset mid-frame: assert `rst` asynchronously during byte 4. Required:
  - all outputs return to reset values without waiting for a clock edge;
  - no further `send_request`;
  - the next `start` with `job_id`=`05`, c=`00`,`00`,`00`,`00` yields `FE 05 00 00 00 00 05`.
- Back-to-back: `start` in the `done` cycle with `job_id`=`80`, c=`FF`,`FF`,`FF`,`FF`. Required: the frame `FE 80 FF FF FF FF 80` follows with no gap beyond one cycle.

Source files
------------

// File: rtl/mat_maven_pkg.sv
// Shared constants and types for the mat-maven datapath.
// Used by the hyperpacket parser, mat_mul and the result transmitter.
package mat_maven_pkg;

  localparam logic [7:0] MATMUL_OPCODE = 8'hFF;
  localparam logic [7:0] RESULT_OPCODE = 8'hFE;
  localparam int FRAME_LEN = 7;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } result_tx_state_t;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  function automatic logic [7:0] frame_sum(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d,
    input logic [7:0] e
  );
    return a ^ b ^ c ^ d ^ e;
  endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// Per-byte UART handshake: request, busy rise or timeout, busy fall.
// Chains straight into the next byte while more is high.
module tx_byte_handshake
  import mat_maven_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic more,
  input  logic tx_busy,
  output logic send_request,
  output logic byte_done,
  output logic idle
);

  localparam int CW = $clog2(ACK_TIMEOUT + 2);

  result_tx_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    send_request = 1'b0;
    byte_done    = 1'b0;
    idle         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        idle = 1'b1;
        if (go) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        send_request = 1'b1;
        cnt_nxt      = CW'(ACK_TIMEOUT);
        state_nxt    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // a silent UART still releases the byte once the count runs out
        if (tx_busy || cnt <= CW'(1)) state_nxt = ST_WAIT_DONE;
        else cnt_nxt = cnt - 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_nxt = more ? ST_SEND : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/result_tx_seq.sv
// Frames one 2x2 mat-mul result as FE, job, c11..c22, xor checksum.
// Holds the snapshot buffer and byte index; handshake owns the UART pacing.
module result_tx_seq
  import mat_maven_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] job_id,
  input  logic [7:0] c11,
  input  logic [7:0] c12,
  input  logic [7:0] c21,
  input  logic [7:0] c22,
  input  logic       tx_busy,
  output logic [7:0] tx_byte,
  output logic       send_request,
  output logic       ready,
  output logic       done,
  output logic       overrun
);

  frame_t           frame;
  logic [IDX_W-1:0] idx;
  logic             done_q;
  logic             ovr_q;
  logic             hs_send;
  logic             hs_done;
  logic             hs_idle;
  logic             accept;
  logic             last;

  assign accept = start & hs_idle;
  assign last   = (idx == IDX_W'(FRAME_LEN - 1));

  tx_byte_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .clk         (clk),
    .rst         (rst),
    .go          (accept),
    .more        (!last),
    .tx_busy     (tx_busy),
    .send_request(hs_send),
    .byte_done   (hs_done),
    .idle        (hs_idle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame  <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= hs_done & last;
      if (start && !hs_idle) ovr_q <= 1'b1;
      if (accept) begin
        frame <= {frame_sum(job_id, c11, c12, c21, c22),
                  c22, c21, c12, c11, job_id, RESULT_OPCODE};
        idx   <= '0;
      end else if (hs_done && !last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign tx_byte      = hs_send ? frame[idx] : 8'h00;
  assign send_request = hs_send;
  assign ready        = hs_idle;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule
